iot_event_arbiter: RTL and testbench
====================================

# iot_event_arbiter

Front-end controller for the active IoT devices monitor. It collects on/off events from up to `N_DEV` independent devices and buffers one event per device. Events are granted round-robin, at most one per cycle, and converted into the monitor's single-cycle `change`/`on_off` command pair. Per-device on/off state is tracked so redundant events (on→on, off→off) are dropped, which keeps the monitor's count equal to the number of devices that are actually on.

## Interface
- `N_DEV`, default 4: number of devices; legal range 2..255.
- `ID_W`, default 2: grant ID width; must equal `$clog2(N_DEV)` (min 1).
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ev_valid` in N_DEV: per-device event strobe.
- `ev_on_off` in N_DEV: per-device event direction; 1 = device turned on, 0 = turned off.
- `ev_ready` out N_DEV: per-device buffer free; an event is accepted when `ev_valid[i] & ev_ready[i]` at the clock edge.
- `hold` in 1: 1 = freeze arbitration; pending events are retained.
- `change` out 1: one-cycle command strobe to the monitor.
- `on_off` out 1: command direction to the monitor; valid when `change=1`.
- `grant_id` out ID_W: device served in the current output cycle.
- `dropped` out 1: one-cycle pulse when a granted event was redundant and discarded.
- `active_mask` out N_DEV: registered per-device on state.
- `active_count` out 8: popcount of `active_mask`.

## Operation
- Per device i:
  - `pend_v[i]` and `pend_dir[i]`: one-deep event buffer.
  - `dev_on[i]`: device state, driven out as `active_mask`.
  - `ev_ready[i] = ~pend_v[i]`, combinational from the register only.
- Accept: on an edge with `ev_valid[i] & ~pend_v[i]`, set `pend_v[i]=1` and `pend_dir[i]=ev_on_off[i]`. `ev_valid` while not ready is ignored (not queued).
- Arbitration, each cycle with `hold=0` and any `pend_v` set:
  - Select the first pending device searching upward (with wrap) from `rr_ptr+1`.
  - At the edge: clear that `pend_v`, set `rr_ptr` to the winner, register `grant_id` = winner.
- Command generation for the winner w at the same edge:
  - If `pend_dir[w] != dev_on[w]`: register `change=1`, `on_off=pend_dir[w]`, `dev_on[w]=pend_dir[w]`, update `active_count` by ±1.
  - Otherwise: register `change=0`, `dropped=1`; state and count are unchanged.
- Idle cycles (no pending events, or `hold=1`): `change=0`, `dropped=0`. `on_off` and `grant_id` hold their last value.
- A served slot frees at the grant edge. A new event for that device is accepted no earlier than the next edge.
- `active_count` never wraps, because it is bounded by `N_DEV` ≤ 255. The monitor therefore never sees a decrement at 0.
- Reset mid-operation: all pending events are discarded and all devices are considered off. The monitor must be reset together with this block.

## Timing
- Reset values: `change=0`, `on_off=0`, `dropped=0`, `grant_id=0`, `active_mask=0`, `active_count=0`, `pend_v=0`, `ev_ready` all 1.
- Reset pointer: `rr_ptr=N_DEV-1`, so device 0 has first priority after reset.
- Latency:
  - Event accepted at edge E0; earliest grant at edge E1.
  - `change` is high in the cycle after E1, and the monitor counts at E2.
  - Uncontended accept-to-`change` latency is 1 cycle.
- Throughput: 1 granted event per cycle (commanded or dropped).
- Fairness: worst-case wait for a pending event is `N_DEV-1` grants.
- `hold` is sampled at each edge:
  - `hold=1` blocks the grant at that edge.
  - Accepts continue while held; `ev_ready` falls as slots fill.
- `change` is never high for two consecutive cycles for the same device unless a new event is accepted in between.

## Test plan
- Reset: hold `rst=1` for 5 cycles, release → all outputs at reset values, `ev_ready=4'b1111`, no `change` pulse for 10 idle cycles.
- Single on event: pulse `ev_valid[0]=1` with `ev_on_off[0]=1` → `change=1`, `on_off=1`, `grant_id=0` one cycle after the accept edge. Then `active_mask=4'b0001`, `active_count=1`, and the monitor `counter_out=1`.
- Simultaneous events: all 4 devices turn on in one cycle → `change` high for 4 consecutive cycles with `grant_id` 0,1,2,3. `active_count=4`; `ev_ready` bits return to 1 in order 0..3.
- Redundant and off events:
  - Turn device 2 on twice (second after the first is served) → second gives `dropped=1`, `change=0`, count unchanged.
  - Turn device 2 off → `change=1`, `on_off=0`, `active_count` decrements.
  - Turn device 3 off while already off → `dropped=1`.
- Fairness: devices 0 and 3 re-issue toggling events whenever ready, 40 cycles → grants alternate strictly between 0 and 3; no device waits more than 1 grant.
- Hold and reset mid-operation:
  - `hold=1` with 3 pending events → no `change` and `ev_ready` stays 0 for those devices; releasing `hold` drains all 3.
  - Assert `rst` with 2 events pending → outputs go to reset values immediately (asynchronously) and the pending events are never issued.

Source files
------------

// File: rtl/iot_event_arbiter_if.sv
// -----------------------------------------------------------------------------
// iot_event_arbiter_if
// Purpose : bundles the per-device event handshake and the monitor command
//           outputs of iot_event_arbiter into one interface.
// Signals :
//   ev_valid     [N_DEV]  per-device event strobe        (master -> slave)
//   ev_on_off    [N_DEV]  per-device event direction     (master -> slave)
//   hold                  freeze arbitration             (master -> slave)
//   ev_ready     [N_DEV]  per-device buffer free         (slave -> master)
//   change                one-cycle command strobe       (slave -> master)
//   on_off                command direction              (slave -> master)
//   grant_id     [ID_W]   device served this cycle       (slave -> master)
//   dropped               redundant event discarded      (slave -> master)
//   active_mask  [N_DEV]  per-device on state            (slave -> master)
//   active_count [8]      popcount of active_mask        (slave -> master)
// -----------------------------------------------------------------------------
interface iot_event_arbiter_if #(
   parameter int N_DEV = 4,
   parameter int ID_W  = 2
);
   logic [N_DEV-1:0] ev_valid;
   logic [N_DEV-1:0] ev_on_off;
   logic             hold;
   logic [N_DEV-1:0] ev_ready;
   logic             change;
   logic             on_off;
   logic [ID_W-1:0]  grant_id;
   logic             dropped;
   logic [N_DEV-1:0] active_mask;
   logic [7:0]       active_count;

   modport master (
      output ev_valid, ev_on_off, hold,
      input  ev_ready, change, on_off, grant_id, dropped, active_mask, active_count
   );

   modport slave (
      input  ev_valid, ev_on_off, hold,
      output ev_ready, change, on_off, grant_id, dropped, active_mask, active_count
   );
endinterface

// File: rtl/iot_event_arbiter.sv
// -----------------------------------------------------------------------------
// iot_event_arbiter
// Purpose : buffers one on/off event per device, grants them round-robin (one
//           per cycle) and turns each into a single-cycle change/on_off command
//           for the active-devices monitor. Per-device on state is tracked so
//           that redundant events (on->on, off->off) are dropped instead of
//           reaching the monitor.
// Ports   :
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - iot_event_arbiter_if.slave (event handshake, hold, command outputs)
// -----------------------------------------------------------------------------
module iot_event_arbiter #(
   parameter int N_DEV = 4,
   parameter int ID_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   iot_event_arbiter_if.slave    bus
);

   logic [N_DEV-1:0] r_pend_v;
   logic [N_DEV-1:0] r_pend_dir;
   logic [N_DEV-1:0] r_dev_on;
   logic [ID_W-1:0]  r_rr_ptr;
   logic             r_change;
   logic             r_on_off;
   logic [ID_W-1:0]  r_grant_id;
   logic             r_dropped;
   logic [7:0]       r_active_count;

   logic             w_found;
   logic [ID_W-1:0]  w_winner;
   logic             w_grant;
   logic             w_win_dir;
   logic             w_win_on;
   logic             w_redundant;

   // Round-robin search: first pending device at rr_ptr+1, rr_ptr+2, ... with wrap.
   always_comb begin
      int idx;
      idx      = 0;
      w_found  = 1'b0;
      w_winner = {ID_W{1'b0}};
      for (int k = 1; k <= N_DEV; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= N_DEV) begin
            idx = idx - N_DEV;
         end else begin
            idx = idx;
         end
         if (!w_found && r_pend_v[ID_W'(idx)]) begin
            w_found  = 1'b1;
            w_winner = ID_W'(idx);
         end else begin
            w_found  = w_found;
            w_winner = w_winner;
         end
      end
   end

   assign w_grant     = w_found & ~bus.hold;
   assign w_win_dir   = r_pend_dir[w_winner];
   assign w_win_on    = r_dev_on[w_winner];
   assign w_redundant = (w_win_dir == w_win_on);

   // One-deep event buffer per device: freed by a grant, filled by an accept.
   // A slot is never granted and accepted at the same edge (accept needs it empty).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_v   <= {N_DEV{1'b0}};
         r_pend_dir <= {N_DEV{1'b0}};
      end else begin
         for (int i = 0; i < N_DEV; i++) begin
            if (w_grant && (w_winner == ID_W'(i))) begin
               r_pend_v[i] <= 1'b0;
            end else if (bus.ev_valid[i] && !r_pend_v[i]) begin
               r_pend_v[i]   <= 1'b1;
               r_pend_dir[i] <= bus.ev_on_off[i];
            end else begin
               r_pend_v[i]   <= r_pend_v[i];
               r_pend_dir[i] <= r_pend_dir[i];
            end
         end
      end
   end

   // Grant bookkeeping and registered monitor command; on_off/grant_id hold when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr       <= ID_W'(N_DEV - 1);
         r_grant_id     <= {ID_W{1'b0}};
         r_change       <= 1'b0;
         r_on_off       <= 1'b0;
         r_dropped      <= 1'b0;
         r_dev_on       <= {N_DEV{1'b0}};
         r_active_count <= 8'd0;
      end else if (w_grant) begin
         r_rr_ptr   <= w_winner;
         r_grant_id <= w_winner;
         if (!w_redundant) begin
            r_change           <= 1'b1;
            r_on_off           <= w_win_dir;
            r_dropped          <= 1'b0;
            r_dev_on[w_winner] <= w_win_dir;
            // Bounded by N_DEV <= 255 and only stepped on a real state change,
            // so this can neither overflow nor underflow.
            if (w_win_dir) begin
               r_active_count <= r_active_count + 8'd1;
            end else begin
               r_active_count <= r_active_count - 8'd1;
            end
         end else begin
            r_change  <= 1'b0;
            r_dropped <= 1'b1;
         end
      end else begin
         r_change  <= 1'b0;
         r_dropped <= 1'b0;
      end
   end

   assign bus.ev_ready     = ~r_pend_v;
   assign bus.change       = r_change;
   assign bus.on_off       = r_on_off;
   assign bus.grant_id     = r_grant_id;
   assign bus.dropped      = r_dropped;
   assign bus.active_mask  = r_dev_on;
   assign bus.active_count = r_active_count;

endmodule

// File: tb/tb_iot_event_arbiter.sv
module tb_iot_event_arbiter;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;
   logic [7:0] mon_count;

   iot_event_arbiter_if #(.N_DEV(4), .ID_W(2)) bus ();

   iot_event_arbiter #(.N_DEV(4), .ID_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference monitor: counts change commands like the downstream monitor does.
   always @(posedge clk or posedge rst) begin
      if (rst) mon_count <= 8'd0;
      else if (bus.change) mon_count <= bus.on_off ? mon_count + 8'd1 : mon_count - 8'd1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.ev_valid = 4'b0000;
      bus.ev_on_off = 4'b0000;
      bus.hold = 1'b0;
      repeat (5) tick();
      rst = 1'b0;
   endtask

   // Pulse one event and advance through its accept edge and grant edge.
   task automatic issue(input int d, input logic dir);
      bus.ev_valid = 4'b0000;
      bus.ev_valid[d] = 1'b1;
      bus.ev_on_off[d] = dir;
      tick();
      bus.ev_valid = 4'b0000;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_total++; if (bus.change !== 1'b0) $display("FAIL reset_change got=%b exp=0", bus.change); else n_pass++;
      n_total++; if (bus.on_off !== 1'b0) $display("FAIL reset_on_off got=%b exp=0", bus.on_off); else n_pass++;
      n_total++; if (bus.dropped !== 1'b0) $display("FAIL reset_dropped got=%b exp=0", bus.dropped); else n_pass++;
      n_total++; if (bus.grant_id !== 2'd0) $display("FAIL reset_grant_id got=%0d exp=0", bus.grant_id); else n_pass++;
      n_total++; if (bus.active_mask !== 4'b0000) $display("FAIL reset_mask got=%b exp=0000", bus.active_mask); else n_pass++;
      n_total++; if (bus.active_count !== 8'd0) $display("FAIL reset_count got=%0d exp=0", bus.active_count); else n_pass++;
      n_total++; if (bus.ev_ready !== 4'b1111) $display("FAIL reset_ready got=%b exp=1111", bus.ev_ready); else n_pass++;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_total++; if (bus.change !== 1'b0) $display("FAIL idle_change cyc=%0d got=%b exp=0", c, bus.change); else n_pass++;
      end
   endtask

   task automatic test_single_on();
      bus.ev_valid = 4'b0001;
      bus.ev_on_off = 4'b0001;
      tick();
      bus.ev_valid = 4'b0000;
      n_total++; if (bus.ev_ready !== 4'b1110) $display("FAIL single_ready_busy got=%b exp=1110", bus.ev_ready); else n_pass++;
      n_total++; if (bus.change !== 1'b0) $display("FAIL single_no_early_change got=%b exp=0", bus.change); else n_pass++;
      tick();
      n_total++; if (bus.change !== 1'b1) $display("FAIL single_change got=%b exp=1", bus.change); else n_pass++;
      n_total++; if (bus.on_off !== 1'b1) $display("FAIL single_on_off got=%b exp=1", bus.on_off); else n_pass++;
      n_total++; if (bus.grant_id !== 2'd0) $display("FAIL single_grant got=%0d exp=0", bus.grant_id); else n_pass++;
      n_total++; if (bus.active_mask !== 4'b0001) $display("FAIL single_mask got=%b exp=0001", bus.active_mask); else n_pass++;
      n_total++; if (bus.active_count !== 8'd1) $display("FAIL single_count got=%0d exp=1", bus.active_count); else n_pass++;
      n_total++; if (bus.ev_ready !== 4'b1111) $display("FAIL single_ready_free got=%b exp=1111", bus.ev_ready); else n_pass++;
      tick();
      n_total++; if (bus.change !== 1'b0) $display("FAIL single_one_pulse got=%b exp=0", bus.change); else n_pass++;
      n_total++; if (mon_count !== 8'd1) $display("FAIL single_monitor got=%0d exp=1", mon_count); else n_pass++;
   endtask

   task automatic test_simultaneous();
      logic [3:0] exp_ready [4];
      exp_ready[0] = 4'b0001; exp_ready[1] = 4'b0011; exp_ready[2] = 4'b0111; exp_ready[3] = 4'b1111;
      do_reset();
      bus.ev_valid = 4'b1111;
      bus.ev_on_off = 4'b1111;
      tick();
      bus.ev_valid = 4'b0000;
      n_total++; if (bus.ev_ready !== 4'b0000) $display("FAIL simul_ready_full got=%b exp=0000", bus.ev_ready); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_total++; if (bus.change !== 1'b1) $display("FAIL simul_change k=%0d got=%b exp=1", k, bus.change); else n_pass++;
         n_total++; if (bus.grant_id !== 2'(k)) $display("FAIL simul_grant k=%0d got=%0d exp=%0d", k, bus.grant_id, k); else n_pass++;
         n_total++; if (bus.ev_ready !== exp_ready[k]) $display("FAIL simul_ready k=%0d got=%b exp=%b", k, bus.ev_ready, exp_ready[k]); else n_pass++;
         n_total++; if (bus.active_count !== 8'(k + 1)) $display("FAIL simul_count k=%0d got=%0d exp=%0d", k, bus.active_count, k + 1); else n_pass++;
      end
      tick();
      n_total++; if (bus.change !== 1'b0) $display("FAIL simul_drained got=%b exp=0", bus.change); else n_pass++;
      n_total++; if (mon_count !== 8'd4) $display("FAIL simul_monitor got=%0d exp=4", mon_count); else n_pass++;
   endtask

   task automatic test_redundant_off();
      do_reset();
      issue(2, 1'b1);
      n_total++; if (bus.change !== 1'b1) $display("FAIL red_first_change got=%b exp=1", bus.change); else n_pass++;
      n_total++; if (bus.active_count !== 8'd1) $display("FAIL red_first_count got=%0d exp=1", bus.active_count); else n_pass++;
      issue(2, 1'b1);
      n_total++; if (bus.dropped !== 1'b1) $display("FAIL red_dup_dropped got=%b exp=1", bus.dropped); else n_pass++;
      n_total++; if (bus.change !== 1'b0) $display("FAIL red_dup_change got=%b exp=0", bus.change); else n_pass++;
      n_total++; if (bus.grant_id !== 2'd2) $display("FAIL red_dup_grant got=%0d exp=2", bus.grant_id); else n_pass++;
      n_total++; if (bus.active_count !== 8'd1) $display("FAIL red_dup_count got=%0d exp=1", bus.active_count); else n_pass++;
      issue(2, 1'b0);
      n_total++; if (bus.change !== 1'b1) $display("FAIL red_off_change got=%b exp=1", bus.change); else n_pass++;
      n_total++; if (bus.on_off !== 1'b0) $display("FAIL red_off_on_off got=%b exp=0", bus.on_off); else n_pass++;
      n_total++; if (bus.dropped !== 1'b0) $display("FAIL red_off_dropped got=%b exp=0", bus.dropped); else n_pass++;
      n_total++; if (bus.active_count !== 8'd0) $display("FAIL red_off_count got=%0d exp=0", bus.active_count); else n_pass++;
      n_total++; if (bus.active_mask !== 4'b0000) $display("FAIL red_off_mask got=%b exp=0000", bus.active_mask); else n_pass++;
      issue(3, 1'b0);
      n_total++; if (bus.dropped !== 1'b1) $display("FAIL red_off3_dropped got=%b exp=1", bus.dropped); else n_pass++;
      n_total++; if (bus.change !== 1'b0) $display("FAIL red_off3_change got=%b exp=0", bus.change); else n_pass++;
      n_total++; if (bus.grant_id !== 2'd3) $display("FAIL red_off3_grant got=%0d exp=3", bus.grant_id); else n_pass++;
      tick();
      n_total++; if (bus.dropped !== 1'b0) $display("FAIL red_drop_pulse got=%b exp=0", bus.dropped); else n_pass++;
      n_total++; if (mon_count !== 8'd0) $display("FAIL red_monitor got=%0d exp=0", mon_count); else n_pass++;
   endtask

   task automatic test_fairness();
      logic [3:0] next_dir;
      logic [1:0] exp_grant;
      logic       gdir0;
      logic       gdir3;
      logic       exp_dir;
      do_reset();
      next_dir = 4'b1111;
      exp_grant = 2'd0;
      gdir0 = 1'b1;
      gdir3 = 1'b1;
      for (int c = 0; c < 40; c++) begin
         bus.ev_valid = 4'b0000;
         if (bus.ev_ready[0]) begin
            bus.ev_valid[0] = 1'b1; bus.ev_on_off[0] = next_dir[0]; next_dir[0] = ~next_dir[0];
         end
         if (bus.ev_ready[3]) begin
            bus.ev_valid[3] = 1'b1; bus.ev_on_off[3] = next_dir[3]; next_dir[3] = ~next_dir[3];
         end
         tick();
         if (c > 0) begin
            exp_dir = (exp_grant == 2'd0) ? gdir0 : gdir3;
            n_total++; if (bus.change !== 1'b1) $display("FAIL fair_change c=%0d got=%b exp=1", c, bus.change); else n_pass++;
            n_total++; if (bus.grant_id !== exp_grant) $display("FAIL fair_grant c=%0d got=%0d exp=%0d", c, bus.grant_id, exp_grant); else n_pass++;
            n_total++; if (bus.on_off !== exp_dir) $display("FAIL fair_on_off c=%0d got=%b exp=%b", c, bus.on_off, exp_dir); else n_pass++;
            if (exp_grant == 2'd0) gdir0 = ~gdir0; else gdir3 = ~gdir3;
            exp_grant = (exp_grant == 2'd0) ? 2'd3 : 2'd0;
         end
      end
      bus.ev_valid = 4'b0000;
      repeat (3) tick();
   endtask

   task automatic test_hold();
      logic [3:0] exp_ready [3];
      exp_ready[0] = 4'b1001; exp_ready[1] = 4'b1011; exp_ready[2] = 4'b1111;
      do_reset();
      bus.hold = 1'b1;
      bus.ev_valid = 4'b0111;
      bus.ev_on_off = 4'b0111;
      tick();
      bus.ev_valid = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) tick();
         n_total++; if (bus.change !== 1'b0) $display("FAIL hold_change c=%0d got=%b exp=0", c, bus.change); else n_pass++;
         n_total++; if (bus.ev_ready !== 4'b1000) $display("FAIL hold_ready c=%0d got=%b exp=1000", c, bus.ev_ready); else n_pass++;
      end
      bus.hold = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_total++; if (bus.change !== 1'b1) $display("FAIL hold_drain_change k=%0d got=%b exp=1", k, bus.change); else n_pass++;
         n_total++; if (bus.grant_id !== 2'(k)) $display("FAIL hold_drain_grant k=%0d got=%0d exp=%0d", k, bus.grant_id, k); else n_pass++;
         n_total++; if (bus.ev_ready !== exp_ready[k]) $display("FAIL hold_drain_ready k=%0d got=%b exp=%b", k, bus.ev_ready, exp_ready[k]); else n_pass++;
      end
      tick();
      n_total++; if (bus.active_mask !== 4'b0111) $display("FAIL hold_mask got=%b exp=0111", bus.active_mask); else n_pass++;
      n_total++; if (mon_count !== 8'd3) $display("FAIL hold_monitor got=%0d exp=3", mon_count); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bus.hold = 1'b1;
      bus.ev_valid = 4'b1010;
      bus.ev_on_off = 4'b1010;
      tick();
      bus.ev_valid = 4'b0000;
      n_total++; if (bus.ev_ready !== 4'b0101) $display("FAIL rmid_pending got=%b exp=0101", bus.ev_ready); else n_pass++;
      #3;
      rst = 1'b1;
      #1;
      n_total++; if (bus.ev_ready !== 4'b1111) $display("FAIL rmid_ready got=%b exp=1111", bus.ev_ready); else n_pass++;
      n_total++; if (bus.active_count !== 8'd0) $display("FAIL rmid_count got=%0d exp=0", bus.active_count); else n_pass++;
      n_total++; if (bus.active_mask !== 4'b0000) $display("FAIL rmid_mask got=%b exp=0000", bus.active_mask); else n_pass++;
      n_total++; if (bus.on_off !== 1'b0) $display("FAIL rmid_on_off got=%b exp=0", bus.on_off); else n_pass++;
      n_total++; if (bus.grant_id !== 2'd0) $display("FAIL rmid_grant got=%0d exp=0", bus.grant_id); else n_pass++;
      tick();
      rst = 1'b0;
      bus.hold = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_total++; if ((bus.change | bus.dropped) !== 1'b0) $display("FAIL rmid_no_issue c=%0d got=%b exp=0", c, bus.change | bus.dropped); else n_pass++;
      end
      n_total++; if (mon_count !== 8'd0) $display("FAIL rmid_monitor got=%0d exp=0", mon_count); else n_pass++;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      rst = 1'b1;
      bus.ev_valid = 4'b0000;
      bus.ev_on_off = 4'b0000;
      bus.hold = 1'b0;
      test_reset();
      test_single_on();
      test_simultaneous();
      test_redundant_off();
      test_fairness();
      test_hold();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
